cc_cond_unit: RTL and testbench

Execute-stage consumer of the 64-bit ALU outputs (result, overflow, 2-bit function select S).
- Latches the Y86 condition codes (ZF, SF, OF) on OPq instructions.
- Evaluates the jXX/cmovXX condition from ifun.
- Registers the E->M pipeline slice (valE, Cnd, valid) with stall/bubble control.
- Sits between the ALU and the memory-stage pipeline register.

---
 rtl/y86_pkg.sv | 27 ++
 rtl/cc_cond_unit_cond_eval.sv | 35 +++
 rtl/cc_cond_unit.sv | 122 ++++++++++++
 tb/tb_cc_cond_unit.sv | 186 ++++++++++++++++++
 4 files changed

// File: rtl/y86_pkg.sv
// y86_pkg: shared Y86 execute-stage definitions.
//   ALU select codes, jXX/cmovXX condition codes, the condition-code
//   struct and its architectural reset value.
package y86_pkg;

  localparam logic [1:0] ALU_ADD = 2'b00;
  localparam logic [1:0] ALU_SUB = 2'b01;
  localparam logic [1:0] ALU_XOR = 2'b10;
  localparam logic [1:0] ALU_AND = 2'b11;

  localparam logic [3:0] C_ALWAYS = 4'd0;
  localparam logic [3:0] C_LE     = 4'd1;
  localparam logic [3:0] C_L      = 4'd2;
  localparam logic [3:0] C_E      = 4'd3;
  localparam logic [3:0] C_NE     = 4'd4;
  localparam logic [3:0] C_GE     = 4'd5;
  localparam logic [3:0] C_G      = 4'd6;

  typedef struct packed {
    logic zf;
    logic sf;
    logic of;
  } cc_t;

  localparam cc_t CC_RESET = '{zf: 1'b1, sf: 1'b0, of: 1'b0};

endpackage

// File: rtl/cc_cond_unit_cond_eval.sv
// cond_eval: combinational jXX/cmovXX condition evaluation.
// Ports:
//   cc_i       condition codes to evaluate against
//   ifun_i     condition function (0..6 valid)
//   cnd_o      condition result (0 for unsupported codes)
//   ifun_err_o high when ifun_i is outside 0..6
module cond_eval
  import y86_pkg::*;
(
  input  cc_t        cc_i,
  input  logic [3:0] ifun_i,
  output logic       cnd_o,
  output logic       ifun_err_o
);

  logic lt;

  assign lt = cc_i.sf ^ cc_i.of;

  always_comb begin
    cnd_o      = 1'b0;
    ifun_err_o = 1'b0;
    case (ifun_i)
      C_ALWAYS: cnd_o = 1'b1;
      C_LE:     cnd_o = lt | cc_i.zf;
      C_L:      cnd_o = lt;
      C_E:      cnd_o = cc_i.zf;
      C_NE:     cnd_o = ~cc_i.zf;
      C_GE:     cnd_o = ~lt;
      C_G:      cnd_o = ~lt & ~cc_i.zf;
      default:  ifun_err_o = 1'b1;
    endcase
  end

endmodule

// File: rtl/cc_cond_unit.sv
// cc_cond_unit: execute-stage condition-code unit and E->M pipeline slice.
//   Latches ZF/SF/OF on OPq instructions, evaluates the jXX/cmovXX
//   condition and registers valE/Cnd/valid into the memory stage.
// Ports:
//   clk, rst              clock, synchronous active-high reset
//   alu_result/overflow   ALU outputs for the instruction in E
//   alu_fn                ALU select (add/sub/xor/and)
//   e_valid, set_cc       E holds a real instruction / instruction is OPq
//   cc_block              suppress CC write (exception downstream)
//   ifun                  condition function
//   m_stall, m_bubble     E->M register hold / clear
//   zf, sf, of            registered condition codes
//   e_cnd, ifun_err       combinational condition result / bad ifun
//   m_val_e, m_cnd, m_valid  registered E->M slice
//   cc_changed            pulse after a CC write that changed the flags
// Build option: CC_UNIT_FWD_EN forwards the flags being written this
//   cycle into the condition evaluation (fused compare-branch).
module cc_cond_unit
  import y86_pkg::*;
#(
  parameter int   WIDTH    = 64,
  parameter logic RESET_ZF = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] alu_result,
  input  logic             alu_overflow,
  input  logic [1:0]       alu_fn,
  input  logic             e_valid,
  input  logic             set_cc,
  input  logic             cc_block,
  input  logic [3:0]       ifun,
  input  logic             m_stall,
  input  logic             m_bubble,
  output logic             zf,
  output logic             sf,
  output logic             of,
  output logic             e_cnd,
  output logic             ifun_err,
  output logic [WIDTH-1:0] m_val_e,
  output logic             m_cnd,
  output logic             m_valid,
  output logic             cc_changed
);

  localparam cc_t CC_RST = '{zf: RESET_ZF, sf: CC_RESET.sf, of: CC_RESET.of};

  cc_t              cc_q, cc_d;
  logic             wr;
  logic             cc_changed_q;
  logic [WIDTH-1:0] m_val_e_q;
  logic             m_cnd_q, m_valid_q;

  // Logical ops cannot overflow, so OF is cleared regardless of the ALU flag.
  always_comb begin
    cc_d.zf = (alu_result == '0);
    cc_d.sf = alu_result[WIDTH-1];
    cc_d.of = ((alu_fn == ALU_ADD) || (alu_fn == ALU_SUB)) ? alu_overflow : 1'b0;
  end

  assign wr = set_cc & e_valid & ~cc_block & ~m_stall;

`ifdef CC_UNIT_FWD_EN
  logic cnd_reg, cnd_fwd, err_reg, err_fwd;

  cond_eval u_cond_reg (
    .cc_i       (cc_q),
    .ifun_i     (ifun),
    .cnd_o      (cnd_reg),
    .ifun_err_o (err_reg)
  );

  cond_eval u_cond_fwd (
    .cc_i       (cc_d),
    .ifun_i     (ifun),
    .cnd_o      (cnd_fwd),
    .ifun_err_o (err_fwd)
  );

  assign e_cnd    = wr ? cnd_fwd : cnd_reg;
  // Both instances decode the same ifun, so either error flag is valid.
  assign ifun_err = err_reg | err_fwd;
`else
  cond_eval u_cond_reg (
    .cc_i       (cc_q),
    .ifun_i     (ifun),
    .cnd_o      (e_cnd),
    .ifun_err_o (ifun_err)
  );
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      cc_q         <= CC_RST;
      cc_changed_q <= 1'b0;
      m_val_e_q    <= '0;
      m_cnd_q      <= 1'b0;
      m_valid_q    <= 1'b0;
    end else begin
      if (wr) cc_q <= cc_d;
      cc_changed_q <= wr & (cc_d != cc_q);
      if (m_bubble) begin
        m_val_e_q <= '0;
        m_cnd_q   <= 1'b0;
        m_valid_q <= 1'b0;
      end else if (!m_stall) begin
        m_val_e_q <= alu_result;
        m_cnd_q   <= e_cnd;
        m_valid_q <= e_valid;
      end
    end
  end

  assign zf         = cc_q.zf;
  assign sf         = cc_q.sf;
  assign of         = cc_q.of;
  assign cc_changed = cc_changed_q;
  assign m_val_e    = m_val_e_q;
  assign m_cnd      = m_cnd_q;
  assign m_valid    = m_valid_q;

endmodule

// File: tb/tb_cc_cond_unit.sv
module tb_cc_cond_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic [63:0] alu_result;
  logic        alu_overflow;
  logic [1:0]  alu_fn;
  logic        e_valid, set_cc, cc_block;
  logic [3:0]  ifun;
  logic        m_stall, m_bubble;
  logic        zf, sf, of, e_cnd, ifun_err, m_cnd, m_valid, cc_changed;
  logic [63:0] m_val_e;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  cc_cond_unit #(.WIDTH(64), .RESET_ZF(1'b1)) dut (
    .clk(clk), .rst(rst), .alu_result(alu_result), .alu_overflow(alu_overflow),
    .alu_fn(alu_fn), .e_valid(e_valid), .set_cc(set_cc), .cc_block(cc_block),
    .ifun(ifun), .m_stall(m_stall), .m_bubble(m_bubble),
    .zf(zf), .sf(sf), .of(of), .e_cnd(e_cnd), .ifun_err(ifun_err),
    .m_val_e(m_val_e), .m_cnd(m_cnd), .m_valid(m_valid), .cc_changed(cc_changed)
  );

  typedef struct {
    logic        rst;
    logic [63:0] res;
    logic        ovf;
    logic [1:0]  fn;
    logic        ev, setcc, blk;
    logic [3:0]  ifn;
    logic        stall, bub;
  } stim_t;

  typedef struct {
    logic        zf, sf, of, chg, cnd, valid;
    logic [63:0] val;
  } exp_t;

  exp_t exp_q[$];

  // reference model state
  logic        mzf, msf, mof, mchg, mcnd, mvalid;
  logic [63:0] mval;
  bit          m_known = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    n_checks++;
    if (obs !== expv) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, obs, expv);
    end
  endtask

  function automatic logic [1:0] ref_cond(input logic [3:0] f, input logic z, input logic s, input logic o);
    // returns {cnd, err}
    if (f == 4'd0)      return 2'b10;
    else if (f == 4'd1) return {((s != o) || z), 1'b0};
    else if (f == 4'd2) return {(s != o), 1'b0};
    else if (f == 4'd3) return {z, 1'b0};
    else if (f == 4'd4) return {!z, 1'b0};
    else if (f == 4'd5) return {(s == o), 1'b0};
    else if (f == 4'd6) return {((s == o) && !z), 1'b0};
    else                return 2'b01;
  endfunction

  task automatic run_cycle(input stim_t s);
    logic       nz, ns, no, w;
    logic [1:0] ce;
    exp_t       e, got;
    rst = s.rst; alu_result = s.res; alu_overflow = s.ovf; alu_fn = s.fn;
    e_valid = s.ev; set_cc = s.setcc; cc_block = s.blk; ifun = s.ifn;
    m_stall = s.stall; m_bubble = s.bub;
    #1;
    nz = (s.res == 64'd0);
    ns = s.res[63];
    no = (s.fn[1] == 1'b0) ? s.ovf : 1'b0;
    w  = s.setcc && s.ev && !s.blk && !s.stall;
`ifdef CC_UNIT_FWD_EN
    ce = w ? ref_cond(s.ifn, nz, ns, no) : ref_cond(s.ifn, mzf, msf, mof);
`else
    ce = ref_cond(s.ifn, mzf, msf, mof);
`endif
    if (m_known) begin
      check("e_cnd", {63'd0, e_cnd}, {63'd0, ce[1]});
      check("ifun_err", {63'd0, ifun_err}, {63'd0, ce[0]});
    end
    if (s.rst) begin
      mzf = 1'b1; msf = 1'b0; mof = 1'b0; mchg = 1'b0;
      mval = 64'd0; mcnd = 1'b0; mvalid = 1'b0;
      m_known = 1;
    end else begin
      mchg = w && ({nz, ns, no} != {mzf, msf, mof});
      if (w) begin mzf = nz; msf = ns; mof = no; end
      if (s.bub) begin
        mval = 64'd0; mcnd = 1'b0; mvalid = 1'b0;
      end else if (!s.stall) begin
        mval = s.res; mcnd = ce[1]; mvalid = s.ev;
      end
    end
    e = '{zf: mzf, sf: msf, of: mof, chg: mchg, cnd: mcnd, valid: mvalid, val: mval};
    if (m_known) exp_q.push_back(e);
    @(posedge clk);
    #1;
    if (exp_q.size() == 0) begin
      if (m_known) check("scoreboard_empty", 64'd0, 64'd1);
    end else begin
      got = exp_q.pop_front();
      check("zf", {63'd0, zf}, {63'd0, got.zf});
      check("sf", {63'd0, sf}, {63'd0, got.sf});
      check("of", {63'd0, of}, {63'd0, got.of});
      check("cc_changed", {63'd0, cc_changed}, {63'd0, got.chg});
      check("m_val_e", m_val_e, got.val);
      check("m_cnd", {63'd0, m_cnd}, {63'd0, got.cnd});
      check("m_valid", {63'd0, m_valid}, {63'd0, got.valid});
    end
  endtask

  stim_t tbl[$];

  function automatic stim_t mk(input logic r, input logic [63:0] res, input logic ovf,
                               input logic [1:0] fn, input logic ev, input logic sc,
                               input logic blk, input logic [3:0] ifn,
                               input logic st, input logic bb);
    stim_t s;
    s.rst = r; s.res = res; s.ovf = ovf; s.fn = fn; s.ev = ev; s.setcc = sc;
    s.blk = blk; s.ifn = ifn; s.stall = st; s.bub = bb;
    return s;
  endfunction

  initial begin
    stim_t s;
    rst = 1'b1; alu_result = '0; alu_overflow = 1'b0; alu_fn = 2'b00;
    e_valid = 1'b0; set_cc = 1'b0; cc_block = 1'b0; ifun = 4'd3;
    m_stall = 1'b0; m_bubble = 1'b0;
    @(posedge clk); #1;

    //           rst res                    ovf fn    ev sc blk ifn  st bb
    tbl.push_back(mk(1, 64'd0,                 0, 2'b00, 0, 0, 0, 4'd3, 0, 0));
    tbl.push_back(mk(1, 64'd0,                 0, 2'b00, 0, 0, 0, 4'd3, 0, 0));
    tbl.push_back(mk(0, 64'd0,                 0, 2'b00, 0, 0, 0, 4'd3, 0, 0));
    tbl.push_back(mk(0, 64'd0,                 0, 2'b01, 1, 1, 0, 4'd0, 0, 0));
    tbl.push_back(mk(0, 64'h8000_0000_0000_0000, 1, 2'b00, 1, 1, 0, 4'd0, 0, 0));
    tbl.push_back(mk(0, 64'd7,                 0, 2'b00, 1, 0, 0, 4'd2, 0, 0));
    tbl.push_back(mk(0, 64'd7,                 0, 2'b00, 1, 0, 0, 4'd1, 0, 0));
    tbl.push_back(mk(0, 64'd5,                 1, 2'b10, 1, 1, 0, 4'd0, 0, 0));
    tbl.push_back(mk(0, 64'd9,                 0, 2'b00, 1, 0, 0, 4'd6, 0, 0));
    tbl.push_back(mk(0, 64'd0,                 0, 2'b01, 1, 1, 1, 4'd9, 0, 0));
    tbl.push_back(mk(0, 64'hAAAA,              0, 2'b00, 1, 0, 0, 4'd4, 0, 0));
    tbl.push_back(mk(0, 64'hBBBB,              0, 2'b01, 1, 1, 0, 4'd5, 1, 0));
    tbl.push_back(mk(0, 64'hCCCC,              1, 2'b00, 1, 1, 0, 4'd0, 1, 0));
    tbl.push_back(mk(0, 64'hDDDD,              0, 2'b00, 1, 0, 0, 4'd0, 1, 1));
    tbl.push_back(mk(0, 64'h1234,              0, 2'b00, 1, 0, 0, 4'd0, 0, 0));
    tbl.push_back(mk(0, 64'hFFFF_0000_0000_0001, 0, 2'b11, 1, 1, 0, 4'd0, 0, 0));
    tbl.push_back(mk(1, 64'h1234,              1, 2'b00, 1, 1, 0, 4'd0, 0, 0));
    tbl.push_back(mk(0, 64'd1,                 0, 2'b00, 1, 0, 0, 4'd3, 0, 0));
    tbl.push_back(mk(0, 64'd0,                 1, 2'b01, 1, 1, 0, 4'd15, 0, 0));

    foreach (tbl[i]) run_cycle(tbl[i]);

    for (int i = 0; i < 400; i++) begin
      s.rst   = ($urandom_range(0, 39) == 0);
      case ($urandom_range(0, 3))
        0:       s.res = 64'd0;
        1:       s.res = {1'b1, 31'($urandom), 32'($urandom)};
        default: s.res = {32'($urandom), 32'($urandom)};
      endcase
      s.ovf   = 1'($urandom);
      s.fn    = 2'($urandom);
      s.ev    = ($urandom_range(0, 4) != 0);
      s.setcc = 1'($urandom);
      s.blk   = ($urandom_range(0, 5) == 0);
      s.ifn   = ($urandom_range(0, 7) == 0) ? 4'($urandom_range(7, 15)) : 4'($urandom_range(0, 6));
      s.stall = ($urandom_range(0, 5) == 0);
      s.bub   = ($urandom_range(0, 6) == 0);
      run_cycle(s);
    end

    check("scoreboard_drained", 64'(exp_q.size()), 64'd0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
